// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe
//  Description : Parametrised multi-stage pipeline register with valid/ready
//                handshake on both sides, bubble collapsing, flush and an
//                occupancy count. STAGES=0 degenerates to a wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    STAGES     = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter int                    CNT_WIDTH  = (STAGES < 1) ? 1 : $clog2(STAGES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    generate
        if (STAGES == 0) begin : g_passthru
            // No storage: both handshakes are wired straight through, still
            // masked by flush so a flush cycle never moves data.
            assign in_ready_o  = out_ready_i & ~flush_i;
            assign out_valid_o = in_valid_i & ~flush_i;
            assign out_data_o  = in_data_i;
            assign count_o     = '0;
        end else begin : g_pipe
            localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

            logic [STAGES-1:0]     r_valid;
            logic [DATA_WIDTH-1:0] r_data [STAGES];
            logic [CNT_WIDTH-1:0]  r_count;

            logic [STAGES-1:0]     w_adv;
            logic [STAGES-1:0]     w_vin;
            logic [DATA_WIDTH-1:0] w_din [STAGES];
            logic                  w_in_xfer;
            logic                  w_out_xfer;

            // Stage k may advance when any stage from k to the output is empty
            // or the consumer is ready; written in closed form so the ready
            // chain has no self-referencing vector.
            always_comb begin
                w_adv = '0;
                for (int k = 0; k < STAGES; k++) begin
                    w_adv[k] = out_ready_i;
                    for (int j = k; j < STAGES; j++) begin
                        if (!r_valid[j]) begin
                            w_adv[k] = 1'b1;
                        end
                    end
                end
            end

            assign in_ready_o  = w_adv[0] & ~flush_i;
            assign out_valid_o = r_valid[STAGES-1] & ~flush_i;
            assign out_data_o  = r_data[STAGES-1];
            assign count_o     = r_count;

            assign w_in_xfer  = in_valid_i & in_ready_o;
            assign w_out_xfer = r_valid[STAGES-1] & out_ready_i & ~flush_i;

            // Incoming valid/data for every stage: the input port for stage 0,
            // the previous stage otherwise.
            always_comb begin
                w_vin    = '0;
                w_vin[0] = w_in_xfer;
                w_din[0] = in_data_i;
                for (int k = 1; k < STAGES; k++) begin
                    w_vin[k] = r_valid[k-1];
                    w_din[k] = r_data[k-1];
                end
            end

            // Stage registers: reset beats flush beats normal advance; data
            // only loads on a valid beat so bubbles never overwrite payload.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_valid <= '0;
                    for (int k = 0; k < STAGES; k++) begin
                        r_data[k] <= RESET_VAL;
                    end
                end else if (flush_i) begin
                    r_valid <= '0;
                end else begin
                    for (int k = 0; k < STAGES; k++) begin
                        if (w_adv[k]) begin
                            r_valid[k] <= w_vin[k];
                            if (w_vin[k]) begin
                                r_data[k] <= w_din[k];
                            end
                        end
                    end
                end
            end

            // Occupancy tracks transfers in and out; simultaneous in+out cancel.
            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    r_count <= '0;
                end else if (w_in_xfer && !w_out_xfer) begin
                    r_count <= r_count + c_one;
                end else if (!w_in_xfer && w_out_xfer) begin
                    r_count <= r_count - c_one;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_pipe
//  Description : Self-checking bench for dff_pipe (STAGES=3 and STAGES=0)
//                with a scoreboard queue of accepted words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe;

    localparam logic [31:0] c_rst_val = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    logic        p_flush;
    logic        p_in_valid;
    logic        p_in_ready;
    logic [31:0] p_in_data;
    logic        p_out_valid;
    logic        p_out_ready;
    logic [31:0] p_out_data;
    logic [0:0]  p_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit lat_chk     = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk;
    } sb_t;

    sb_t sb_q[$];

    dff_pipe #(.DATA_WIDTH(32), .STAGES(3), .RESET_VAL(c_rst_val)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .count_o(count)
    );

    dff_pipe #(.DATA_WIDTH(32), .STAGES(0), .RESET_VAL(c_rst_val)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(p_flush),
        .in_valid_i(p_in_valid), .in_ready_o(p_in_ready), .in_data_i(p_in_data),
        .out_valid_o(p_out_valid), .out_ready_i(p_out_ready), .out_data_o(p_out_data),
        .count_o(p_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop/compare on each output transfer, push on each input
    // transfer; both sampled mid-cycle so they match what the next edge does.
    always @(negedge clk) begin
        sb_t e;
        if (rst === 1'b0) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: got data %h, expected no output", out_data);
                end else begin
                    e = sb_q.pop_front();
                    if (out_data !== e.data) begin
                        miscompares++;
                        $display("FAIL sb_data: got %h, expected %h", out_data, e.data);
                    end
                    if (e.chk && lat_chk && (cyc - e.cyc) != 3) begin
                        miscompares++;
                        $display("FAIL sb_latency: got %0d cycles, expected 3", cyc - e.cyc);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb_q.push_back('{data: in_data, cyc: cyc, chk: lat_chk});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        vectors++;
        if (out_data !== c_rst_val) begin miscompares++; $display("FAIL reset_out_data: got %h, expected %h", out_data, c_rst_val); end
        vectors++;
        if (count !== 2'd0) begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", count); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        tick();
    endtask

    task automatic test_streaming();
        lat_chk = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready word %0d: got %b, expected 1", i, in_ready); end
            if (i >= 4) begin
                vectors++;
                if (count !== 2'd3) begin miscompares++; $display("FAIL stream_count word %0d: got %0d, expected 3", i, count); end
                vectors++;
                if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_gap word %0d: got out_valid %b, expected 1", i, out_valid); end
            end
            tick();
        end
        in_valid = 1'b0; in_data = '0;
        for (int t = 0; t < 20 && sb_q.size() != 0; t++) tick();
        vectors++;
        if (sb_q.size() != 0) begin miscompares++; $display("FAIL stream_drain: got %0d pending, expected 0", sb_q.size()); end
        lat_chk = 1'b0;
    endtask

    task automatic test_backpressure();
        lat_chk = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA1; tick();
        in_valid = 1'b0;                   tick();
        in_valid = 1'b1; in_data = 32'hA2; tick();
        in_data = 32'hA3;                  tick();
        in_data = 32'hA4;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            vectors++;
            if (count !== 2'd3) begin miscompares++; $display("FAIL bp_count stall %0d: got %0d, expected 3", s, count); end
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready stall %0d: got %b, expected 0", s, in_ready); end
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'hA1) begin
                miscompares++;
                $display("FAIL bp_hold stall %0d: got valid %b data %h, expected 1 a1", s, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_swap: got in_ready %b out_valid %b, expected 1 1", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0; in_data = '0;
        for (int t = 0; t < 20 && sb_q.size() != 0; t++) tick();
        vectors++;
        if (sb_q.size() != 0 || count !== 2'd0) begin
            miscompares++;
            $display("FAIL bp_drain: got %0d pending count %0d, expected 0 0", sb_q.size(), count);
        end
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; tick();
        in_data = 32'h22;                  tick();
        in_valid = 1'b0; in_data = '0;     tick();
        @(negedge clk);
        vectors++;
        if (count !== 2'd2 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre: got count %0d out_valid %b, expected 2 1", count, out_valid);
        end
        tick();
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_mask: got in_ready %b out_valid %b, expected 0 0", in_ready, out_valid);
        end
        tick();
        sb_q.delete();
        flush = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        vectors++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_post: got count %0d out_valid %b, expected 0 0", count, out_valid);
        end
        seen = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL flush_leak: got %0d valid cycles, expected 0", seen); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hC1; tick();
        in_data = 32'hC2;                  tick();
        in_data = 32'hC3;                  tick();
        in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        vectors++;
        if (count !== 2'd3) begin miscompares++; $display("FAIL rmid_pre: got count %0d, expected 3", count); end
        tick();
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'h99;
        tick();
        sb_q.delete();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        vectors++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== c_rst_val || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_state: got count %0d valid %b data %h ready %b, expected 0 0 %h 1",
                     count, out_valid, out_data, in_ready, c_rst_val);
        end
        tick();
        lat_chk = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h77;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_accept: got %b, expected 1", in_ready); end
        tick();
        in_valid = 1'b0; in_data = '0;
        lat = 0;
        for (int t = 1; t <= 10 && lat == 0; t++) begin
            @(negedge clk);
            if (out_valid === 1'b1) lat = t;
            else tick();
        end
        vectors++;
        if (lat != 3 || out_data !== 32'h77) begin
            miscompares++;
            $display("FAIL rmid_latency: got %0d cycles data %h, expected 3 77", lat, out_data);
        end
        tick();
        lat_chk = 1'b0;
    endtask

    task automatic test_passthru();
        logic exp_rdy;
        p_flush = 1'b0; p_in_valid = 1'b1; p_in_data = 32'h3C;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2) == 1;
            p_out_ready = exp_rdy;
            @(negedge clk);
            vectors++;
            if (p_out_valid !== 1'b1 || p_out_data !== 32'h3C) begin
                miscompares++;
                $display("FAIL pt_fwd %0d: got valid %b data %h, expected 1 3c", i, p_out_valid, p_out_data);
            end
            vectors++;
            if (p_in_ready !== exp_rdy || p_count !== 1'b0) begin
                miscompares++;
                $display("FAIL pt_ready %0d: got ready %b count %0d, expected %b 0", i, p_in_ready, p_count, exp_rdy);
            end
            tick();
        end
        p_flush = 1'b1; p_out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (p_out_valid !== 1'b0 || p_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pt_flush: got valid %b ready %b, expected 0 0", p_out_valid, p_in_ready);
        end
        tick();
        p_flush = 1'b0; p_in_valid = 1'b0;
    endtask

    initial begin
        p_flush = 1'b0; p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_passthru();
        vectors++;
        if (sb_q.size() != 0) begin miscompares++; $display("FAIL final_sb: got %0d pending, expected 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
